// File: rtl/estagio_escrita.sv
// Write-back stage: merges ULA results and memory loads into one write port.
// Optional macro PROTEGE_ZERO_EN suppresses every write to register 0.
module estagio_escrita #(
    parameter int LARG_DADO = 32,
    parameter int LARG_END  = 6,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ula_valido,
    input  logic [LARG_END-1:0]  ula_end,
    input  logic [LARG_DADO-1:0] ula_dado,
    input  logic                 load_inicia,
    input  logic [LARG_END-1:0]  load_end,
    input  logic                 mem_pronto,
    input  logic [LARG_DADO-1:0] mem_dado,
    output logic [LARG_END-1:0]  end_escrita,
    output logic [LARG_DADO-1:0] dados_escrita,
    output logic                 EscreveReg,
    output logic                 pausa,
    output logic [LARG_END-1:0]  pendente_end,
    output logic                 erro_mem
);

    localparam int LARG_CONT = $clog2(TIMEOUT);
    localparam logic [LARG_CONT-1:0] CONT_MAX =
        LARG_CONT'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        AGUARDA_MEM,
        ERRO
    } estado_t;

    estado_t               estado;
    estado_t               estado_prox;
    logic [LARG_CONT-1:0]  cont;
    logic [LARG_CONT-1:0]  cont_prox;
    logic                  erro_prox;
    logic                  captura_load;
    logic                  esc_pedido;
    logic                  esc_aceita;
    logic [LARG_END-1:0]   esc_end;
    logic [LARG_DADO-1:0]  esc_dado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            cont     <= '0;
            erro_mem <= 1'b0;
        end else begin
            estado   <= estado_prox;
            cont     <= cont_prox;
            erro_mem <= erro_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        cont_prox    = cont;
        erro_prox    = erro_mem;
        captura_load = 1'b0;
        esc_pedido   = 1'b0;
        esc_end      = ula_end;
        esc_dado     = ula_dado;
        unique case (estado)
            OCIOSO: begin
                esc_pedido = ula_valido;
                if (load_inicia) begin
                    captura_load = 1'b1;
                    cont_prox    = '0;
                    estado_prox  = AGUARDA_MEM;
                end
            end
            AGUARDA_MEM: begin
                // A late answer on the last allowed cycle still counts.
                if (mem_pronto) begin
                    esc_pedido  = 1'b1;
                    esc_end     = pendente_end;
                    esc_dado    = mem_dado;
                    estado_prox = OCIOSO;
                end else if (cont == CONT_MAX) begin
                    estado_prox = ERRO;
                    erro_prox   = 1'b1;
                end else begin
                    cont_prox = cont + 1'b1;
                end
            end
            ERRO: begin
                erro_prox = 1'b1;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

`ifdef PROTEGE_ZERO_EN
    assign esc_aceita = esc_pedido && (esc_end != '0);
`else
    assign esc_aceita = esc_pedido;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            end_escrita   <= '0;
            dados_escrita <= '0;
            EscreveReg    <= 1'b0;
            pendente_end  <= '0;
        end else begin
            EscreveReg <= esc_aceita;
            if (esc_aceita) begin
                end_escrita   <= esc_end;
                dados_escrita <= esc_dado;
            end
            if (captura_load) begin
                pendente_end <= load_end;
            end
        end
    end

    assign pausa = (estado != OCIOSO);

endmodule

// File: tb/tb_estagio_escrita.sv
// Directed bench for estagio_escrita; second instance uses TIMEOUT=4.
module tb_estagio_escrita;

    logic        clock = 1'b0;
    logic        reset;
    logic        ula_valido;
    logic [5:0]  ula_end;
    logic [31:0] ula_dado;
    logic        load_inicia;
    logic [5:0]  load_end;
    logic        mem_pronto;
    logic [31:0] mem_dado;

    logic [5:0]  end_escrita;
    logic [31:0] dados_escrita;
    logic        EscreveReg;
    logic        pausa;
    logic [5:0]  pendente_end;
    logic        erro_mem;

    logic [5:0]  t_end;
    logic [31:0] t_dados;
    logic        t_we;
    logic        t_pausa;
    logic [5:0]  t_pend;
    logic        t_erro;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    estagio_escrita u_dut (
        .clock        (clock),
        .reset        (reset),
        .ula_valido   (ula_valido),
        .ula_end      (ula_end),
        .ula_dado     (ula_dado),
        .load_inicia  (load_inicia),
        .load_end     (load_end),
        .mem_pronto   (mem_pronto),
        .mem_dado     (mem_dado),
        .end_escrita  (end_escrita),
        .dados_escrita(dados_escrita),
        .EscreveReg   (EscreveReg),
        .pausa        (pausa),
        .pendente_end (pendente_end),
        .erro_mem     (erro_mem)
    );

    estagio_escrita #(.TIMEOUT(4)) u_to (
        .clock        (clock),
        .reset        (reset),
        .ula_valido   (ula_valido),
        .ula_end      (ula_end),
        .ula_dado     (ula_dado),
        .load_inicia  (load_inicia),
        .load_end     (load_end),
        .mem_pronto   (mem_pronto),
        .mem_dado     (mem_dado),
        .end_escrita  (t_end),
        .dados_escrita(t_dados),
        .EscreveReg   (t_we),
        .pausa        (t_pausa),
        .pendente_end (t_pend),
        .erro_mem     (t_erro)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ula_valido  = 1'b1;
        ula_end     = 6'd5;
        ula_dado    = 32'h1;
        load_inicia = 1'b0;
        load_end    = 6'd0;
        mem_pronto  = 1'b0;
        mem_dado    = 32'h0;

        // 1: reset holds outputs low despite ula_valido
        step();
        step();
        chk("rst_we", 32'(EscreveReg), 32'd0);
        chk("rst_pausa", 32'(pausa), 32'd0);
        chk("rst_erro", 32'(erro_mem), 32'd0);
        chk("rst_end", 32'(end_escrita), 32'd0);
        chk("rst_dados", dados_escrita, 32'd0);
        chk("rst_pend", 32'(pendente_end), 32'd0);
        reset      = 1'b0;
        ula_valido = 1'b0;
        step();

        // 2: ULA write, one-cycle pulse
        ula_valido = 1'b1;
        ula_end    = 6'd5;
        ula_dado   = 32'h1234;
        step();
        ula_valido = 1'b0;
        chk("ula_we", 32'(EscreveReg), 32'd1);
        chk("ula_end", 32'(end_escrita), 32'd5);
        chk("ula_dados", dados_escrita, 32'h1234);
        chk("ula_pausa", 32'(pausa), 32'd0);
        step();
        chk("ula_we_off", 32'(EscreveReg), 32'd0);

        // 3: load answered after 7 stalled cycles
        load_inicia = 1'b1;
        load_end    = 6'd9;
        step();
        load_inicia = 1'b0;
        chk("ld_pausa0", 32'(pausa), 32'd1);
        chk("ld_pend", 32'(pendente_end), 32'd9);
        chk("ld_we0", 32'(EscreveReg), 32'd0);
        for (int i = 1; i < 7; i++) begin
            step();
            chk("ld_pausa", 32'(pausa), 32'd1);
            chk("ld_we", 32'(EscreveReg), 32'd0);
        end
        mem_pronto = 1'b1;
        mem_dado   = 32'hCAFE;
        step();
        mem_pronto = 1'b0;
        chk("ld_we1", 32'(EscreveReg), 32'd1);
        chk("ld_end", 32'(end_escrita), 32'd9);
        chk("ld_dados", dados_escrita, 32'hCAFE);
        chk("ld_pausa1", 32'(pausa), 32'd0);
        step();
        chk("ld_we_off", 32'(EscreveReg), 32'd0);

        // 4: ULA and load in the same cycle
        ula_valido  = 1'b1;
        ula_end     = 6'd3;
        ula_dado    = 32'h11;
        load_inicia = 1'b1;
        load_end    = 6'd4;
        step();
        load_inicia = 1'b0;
        ula_end     = 6'd7;
        ula_dado    = 32'h55;
        chk("both_we", 32'(EscreveReg), 32'd1);
        chk("both_end", 32'(end_escrita), 32'd3);
        chk("both_dados", dados_escrita, 32'h11);
        chk("both_pausa", 32'(pausa), 32'd1);
        chk("both_pend", 32'(pendente_end), 32'd4);
        step();
        ula_valido = 1'b0;
        chk("stall_we", 32'(EscreveReg), 32'd0);
        chk("stall_dados", dados_escrita, 32'h11);
        mem_pronto = 1'b1;
        mem_dado   = 32'hBEEF;
        step();
        chk("both_mwe", 32'(EscreveReg), 32'd1);
        chk("both_mend", 32'(end_escrita), 32'd4);
        chk("both_mdados", dados_escrita, 32'hBEEF);
        chk("both_mpausa", 32'(pausa), 32'd0);
        mem_dado = 32'hDEAD;
        step();
        mem_pronto = 1'b0;
        chk("idle_mem_we", 32'(EscreveReg), 32'd0);
        chk("idle_mem_dados", dados_escrita, 32'hBEEF);

        // 5: timeout with TIMEOUT=4
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("to_rst_erro", 32'(t_erro), 32'd0);
        load_inicia = 1'b1;
        load_end    = 6'd2;
        step();
        load_inicia = 1'b0;
        chk("to_pausa0", 32'(t_pausa), 32'd1);
        step();
        step();
        step();
        chk("to_erro_early", 32'(t_erro), 32'd0);
        step();
        chk("to_erro", 32'(t_erro), 32'd1);
        chk("to_pausa", 32'(t_pausa), 32'd1);
        mem_pronto = 1'b1;
        mem_dado   = 32'h77;
        ula_valido = 1'b1;
        ula_end    = 6'd6;
        step();
        mem_pronto = 1'b0;
        ula_valido = 1'b0;
        chk("to_late_we", 32'(t_we), 32'd0);
        chk("to_sticky", 32'(t_erro), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("to_clr_erro", 32'(t_erro), 32'd0);
        chk("to_clr_pausa", 32'(t_pausa), 32'd0);

        // mem_pronto on the timeout cycle wins
        load_inicia = 1'b1;
        load_end    = 6'd12;
        step();
        load_inicia = 1'b0;
        step();
        step();
        step();
        mem_pronto = 1'b1;
        mem_dado   = 32'hABCD;
        step();
        mem_pronto = 1'b0;
        chk("race_we", 32'(t_we), 32'd1);
        chk("race_end", 32'(t_end), 32'd12);
        chk("race_dados", t_dados, 32'hABCD);
        chk("race_erro", 32'(t_erro), 32'd0);
        chk("race_pausa", 32'(t_pausa), 32'd0);

        // reset mid-load abandons it
        reset = 1'b1;
        step();
        reset       = 1'b0;
        load_inicia = 1'b1;
        load_end    = 6'd8;
        step();
        load_inicia = 1'b0;
        reset       = 1'b1;
        step();
        reset      = 1'b0;
        mem_pronto = 1'b1;
        mem_dado   = 32'h99;
        step();
        mem_pronto = 1'b0;
        chk("abort_we", 32'(EscreveReg), 32'd0);
        chk("abort_pausa", 32'(pausa), 32'd0);
        chk("abort_dados", dados_escrita, 32'd0);

        // 6: write to register 0
        ula_valido = 1'b1;
        ula_end    = 6'd0;
        ula_dado   = 32'h7;
        step();
        ula_valido = 1'b0;
`ifdef PROTEGE_ZERO_EN
        chk("r0_we", 32'(EscreveReg), 32'd0);
        chk("r0_dados", dados_escrita, 32'd0);
`else
        chk("r0_we", 32'(EscreveReg), 32'd1);
        chk("r0_dados", dados_escrita, 32'h7);
`endif
        chk("r0_end", 32'(end_escrita), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
